pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Registered program-counter sequencer that consumes PC-adder results. It holds PC and selects the next PC from one of four sources: sequential step, PC-relative branch, absolute jump, or call/return through a small return-address stack (RAS). It sits at the front of the fetch stage and drives instruction-memory address.

Parameters:
WIDTH, 16, PC / address width in bits
STEP, 2, sequential increment (bytes per instruction)
RESET_PC, 16'h0000, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
CLK  input  1  rising-edge clock
RESET_N  input  1  asynchronous, active-low reset
EN  input  1  advance PC this cycle; 0 = stall/hold
OP  input  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101-111 treated as SEQ
COND  input  1  branch taken qualifier, used only by BRANCH
OFFSET  input  WIDTH  two's-complement branch offset
TARGET  input  WIDTH  absolute jump/call target
PC  output  WIDTH  current program counter (registered)
RAS_COUNT  output  log2(RAS_DEPTH)+1  valid RAS entries
RAS_FULL  output  1  RAS_COUNT == RAS_DEPTH
RAS_EMPTY  output  1  RAS_COUNT == 0
FAULT  output  1  sticky RAS overflow/underflow flag

Behaviour:
- Reset (async, RESET_N=0): PC=RESET_PC, RAS_COUNT=0, RAS_EMPTY=1, RAS_FULL=0, FAULT=0; RAS contents don't-care. Reset asserted mid-operation overrides everything immediately. The first update occurs on the first rising CLK edge with RESET_N=1.
- EN=0: PC, RAS and FAULT hold; OP, COND, OFFSET and TARGET are ignored.
- EN=1, update on the rising edge (1-cycle latency; the new PC is visible after the edge):
  - SEQ: PC <= PC+STEP.
  - BRANCH: if COND, PC <= PC+OFFSET (relative to current PC, not PC+STEP); else PC <= PC+STEP.
  - JUMP: PC <= TARGET.
  - CALL: PC <= TARGET.
    - If not full: push PC+STEP, RAS_COUNT+1.
    - If full: no push, stack unchanged, FAULT <= 1.
  - RET:
    - If not empty: PC <= top entry, pop, RAS_COUNT-1.
    - If empty: PC <= PC+STEP, FAULT <= 1.
- Arithmetic: all sums are modulo 2^WIDTH; wrap silently with no flag (e.g. 16'hFFFE+2 = 16'h0000). OFFSET is added as a WIDTH-bit value, so a negative offset wraps correctly.
- RAS is LIFO. Entries are implemented as an array plus a pointer; no read of stale entries is allowed. Push and pop never occur in the same cycle, because OP is single-valued.
- FAULT is sticky and is cleared only by reset.
- RAS_FULL and RAS_EMPTY are derived combinationally from RAS_COUNT registered state. No X on any output after reset.

Test Plan:
1. Reset/SEQ: hold RESET_N=0, then release; EN=1, OP=SEQ for 3 cycles -> PC 0x0000, 0x0002, 0x0004, 0x0006. Assert RESET_N=0 mid-clock -> PC=0x0000 immediately, without waiting for an edge.
2. Stall + branch: PC=0x0010, EN=0 for 2 cycles -> PC stays 0x0010. Then EN=1, BRANCH, COND=1, OFFSET=0xFFF8 -> PC=0x0008. Then BRANCH, COND=0 -> PC=0x000A.
3. Wrap: JUMP TARGET=0xFFFC, then SEQ x2 -> PC 0xFFFE, 0x0000; FAULT remains 0.
4. Call/return nesting: at PC=0x0100, CALL 0x0200, then CALL 0x0300 -> RAS_COUNT=2. RET -> PC=0x0202. RET -> PC=0x0102, RAS_EMPTY=1.
5. Overflow: 4 CALLs from PCs 0x10, 0x20, 0x30, 0x40 (targets 0x20, 0x30, 0x40, 0x50) -> RAS_FULL=1. A 5th CALL to 0x60 -> PC=0x0060, FAULT=1, RAS_COUNT=4. 4 RETs -> PC 0x0042, 0x0032, 0x0022, 0x0012.
6. Underflow: after reset, RET at PC=0x0000 -> PC=0x0002, FAULT=1, RAS_COUNT=0. FAULT stays 1 through further SEQ and CALL until RESET_N=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential, branch, jump and call/return
// through a small return-address stack, with a sticky RAS overflow/underflow fault.
module pc_sequencer #(
    parameter int unsigned       WIDTH     = 16,
    parameter int unsigned       STEP      = 2,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic [2:0]                     op,
    input  logic                           cond,
    input  logic [WIDTH-1:0]               offset,
    input  logic [WIDTH-1:0]               target,
    output logic [WIDTH-1:0]               pc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           fault
);

    localparam int unsigned PW   = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PW + 1;

    localparam logic [WIDTH-1:0] StepW   = WIDTH'(STEP);
    localparam logic [CntW-1:0]  FullCnt = CntW'(RAS_DEPTH);
    localparam logic [CntW-1:0]  OneCnt  = CntW'(1);
    localparam logic [PW-1:0]    OneIdx  = PW'(1);

    typedef enum logic [2:0] {
        OpSeq    = 3'b000,
        OpBranch = 3'b001,
        OpJump   = 3'b010,
        OpCall   = 3'b011,
        OpRet    = 3'b100
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic             push;
    logic [WIDTH-1:0] pc_seq;
    logic [PW-1:0]    push_idx;
    logic [PW-1:0]    top_idx;
    logic             full;
    logic             empty;

    assign full     = (cnt_q == FullCnt);
    assign empty    = (cnt_q == '0);
    assign pc_seq   = pc_q + StepW;
    // Low bits of the count wrap to 0 when full, so count-1 still names the top entry.
    assign push_idx = cnt_q[PW-1:0];
    assign top_idx  = cnt_q[PW-1:0] - OneIdx;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (en) begin
            case (op_e'(op))
                OpBranch: pc_d = cond ? (pc_q + offset) : pc_seq;
                OpJump:   pc_d = target;
                OpCall: begin
                    pc_d = target;
                    if (full) begin
                        fault_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + OneCnt;
                    end
                end
                OpRet: begin
                    if (empty) begin
                        pc_d    = pc_seq;
                        fault_d = 1'b1;
                    end else begin
                        pc_d  = ras_mem[top_idx];
                        cnt_d = cnt_q - OneCnt;
                    end
                end
                default:  pc_d = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Stack contents need no reset: entries are only read below the valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[push_idx] <= pc_seq;
        end
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign ras_full  = full;
    assign ras_empty = empty;
    assign fault     = fault_q;

endmodule
